// File: rtl/unary_add_arb.sv
// Round-robin sequencer that shares one unary bitstream adder among NREQ requesters.
// Each granted job clears the adder, streams LEN cycles of the winner's A/B bits,
// then reads the adder back for 2*LEN cycles and counts the ones into result.
module unary_add_arb #(
    parameter int NREQ = 2,
    parameter int LEN  = 16,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            done,
    output logic            abort,
    output logic [CW-1:0]   result,
    output logic            ovf,
    output logic            add_en,
    output logic            add_a,
    output logic            add_b,
    output logic            add_rw,
    output logic            add_rst_n,
    input  logic            add_dout,
    input  logic            add_c
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(2 * LEN + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   RES_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_READ,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gntIdx;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_done;
    logic            r_abort;
    logic [CW-1:0]   r_result;
    logic            r_ovf;
    logic            r_addEn;
    logic            r_addRw;
    logic            r_addRstN;
    logic [CNTW-1:0] r_cnt;
    logic [CW-1:0]   r_shadowResult;
    logic            r_shadowOvf;

    logic            w_found;
    logic [PW-1:0]   w_winIdx;
    logic [PW-1:0]   w_cand;
    logic [PW-1:0]   w_nextPtr;
    logic            w_gntReq;
    logic            w_resMax;

    // Pick the first requester at or after the round-robin pointer, wrapping to 0.
    always_comb begin
        w_found  = 1'b0;
        w_winIdx = '0;
        w_cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = PW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winIdx = w_cand;
            end
        end
    end

    assign w_nextPtr = (w_winIdx == PW'(NREQ - 1)) ? '0 : w_winIdx + PW'(1);
    assign w_gntReq  = req[r_gntIdx];
    assign w_resMax  = (r_result == RES_MAX);

    // Operand bits reach the adder only while accumulating; zero otherwise.
    assign add_a = (r_state == S_ACCUM) ? req_a[r_gntIdx] : 1'b0;
    assign add_b = (r_state == S_ACCUM) ? req_b[r_gntIdx] : 1'b0;

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign abort     = r_abort;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign add_en    = r_addEn;
    assign add_rw    = r_addRw;
    assign add_rst_n = r_addRstN;

    // Job sequencer: every output register is loaded with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_gntIdx       <= '0;
            r_gnt          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_abort        <= 1'b0;
            r_result       <= '0;
            r_ovf          <= 1'b0;
            r_addEn        <= 1'b0;
            r_addRw        <= 1'b0;
            r_addRstN      <= 1'b0;
            r_cnt          <= '0;
            r_shadowResult <= '0;
            r_shadowOvf    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_addEn <= 1'b0;
                    r_addRw <= 1'b0;
                    if (w_found) begin
                        r_state        <= S_CLEAR;
                        r_gntIdx       <= w_winIdx;
                        r_gnt          <= ONE_HOT0 << w_winIdx;
                        r_ptr          <= w_nextPtr;
                        r_busy         <= 1'b1;
                        r_addRstN      <= 1'b0;
                        r_cnt          <= '0;
                        r_shadowResult <= r_result;
                        r_shadowOvf    <= r_ovf;
                        r_ovf          <= 1'b0;
                    end else begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_addRstN <= 1'b1;
                    end
                end
                S_CLEAR, S_ACCUM, S_READ: begin
                    if (!w_gntReq) begin
                        // Winner withdrew: drop the job and put the previous result back.
                        r_state   <= S_IDLE;
                        r_abort   <= 1'b1;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_addEn   <= 1'b0;
                        r_addRw   <= 1'b0;
                        r_addRstN <= 1'b0;
                        r_result  <= r_shadowResult;
                        r_ovf     <= r_shadowOvf;
                    end else if (r_state == S_CLEAR) begin
                        r_state   <= S_ACCUM;
                        r_cnt     <= '0;
                        r_addEn   <= 1'b1;
                        r_addRw   <= 1'b0;
                        r_addRstN <= 1'b1;
                    end else if (r_state == S_ACCUM) begin
                        r_ovf <= r_ovf | add_c;
                        if (r_cnt == CNTW'(LEN - 1)) begin
                            r_state  <= S_READ;
                            r_cnt    <= '0;
                            r_addRw  <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end else begin
                        r_ovf <= r_ovf | add_c | (add_dout & w_resMax);
                        if (add_dout && !w_resMax) begin
                            r_result <= r_result + CW'(1);
                        end
                        if (r_cnt == CNTW'(2 * LEN - 1)) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                            r_addEn <= 1'b0;
                            r_addRw <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_addEn   <= 1'b0;
                    r_addRw   <= 1'b0;
                    r_addRstN <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_add_arb.sv
// Self-checking bench for unary_add_arb: randomized jobs against a job-level reference model.
module tb_unary_add_arb;

    localparam int NREQ   = 2;
    localparam int LEN    = 16;
    localparam int CW     = 5;
    localparam int RESMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_a;
    logic [NREQ-1:0] req_b;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic            abort;
    logic [CW-1:0]   result;
    logic            ovf;
    logic            add_en;
    logic            add_a;
    logic            add_b;
    logic            add_rw;
    logic            add_rst_n;
    logic            add_dout;
    logic            add_c;

    int   testsRun  = 0;
    int   failCount = 0;
    int   rrPtr     = 0;
    int   expResult = 0;
    logic expOvf    = 1'b0;

    unary_add_arb #(.NREQ(NREQ), .LEN(LEN), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .busy(busy), .done(done), .abort(abort),
        .result(result), .ovf(ovf), .add_en(add_en), .add_a(add_a),
        .add_b(add_b), .add_rw(add_rw), .add_rst_n(add_rst_n),
        .add_dout(add_dout), .add_c(add_c)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        testsRun++;
        if (got !== expv) begin
            failCount++;
            $display("[TB] FAIL %s got=%0d required=%0d", tag, got, expv);
        end
    endtask

    task automatic garbage();
        add_dout = 1'($urandom_range(0, 1));
        add_c    = 1'($urandom_range(0, 1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_gnt"},  32'(gnt), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_abrt"}, 32'(abort), 0);
        checkOutput({tag, "_res"},  32'(result), 0);
        checkOutput({tag, "_ovf"},  32'(ovf), 0);
        checkOutput({tag, "_en"},   32'(add_en), 0);
        checkOutput({tag, "_rw"},   32'(add_rw), 0);
        checkOutput({tag, "_rstn"}, 32'(add_rst_n), 0);
    endtask

    task automatic idleCycles(input int n);
        req = '0;
        garbage();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            checkOutput("idle_busy", 32'(busy), 0);
            checkOutput("idle_done", 32'(done), 0);
            garbage();
        end
    endtask

    // One job from the IDLE cycle where req is presented. dropCyc/rstCyc (0 = none) pick the
    // cycle in which the winner's req is withdrawn or rst is pulsed.
    // doutMode: 0 random, 1 all ones, 2 alternating. cMode: 0 none, 1 sparse random, 2 one ACCUM pulse.
    task automatic applyStimulus(input logic [NREQ-1:0] reqMask, input int dropCyc,
                                 input int rstCyc, input int doutMode, input int cMode);
        int              win;
        int              idx;
        int              onesCnt;
        int              total;
        logic            cSeen;
        logic            patBit;
        logic [NREQ-1:0] expGnt;
        logic [NREQ-1:0] other;
        total = 3 * LEN + 2;
        win   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (rrPtr + i) % NREQ;
            if (reqMask[idx]) win = idx;
        end
        expGnt      = '0;
        expGnt[win] = 1'b1;
        other       = reqMask & ~expGnt;
        checkOutput("start_busy", 32'(busy), 0);
        req = reqMask;
        garbage();
        rrPtr   = (win + 1) % NREQ;
        onesCnt = 0;
        cSeen   = 1'b0;
        for (int cyc = 1; cyc <= total; cyc++) begin
            @(posedge clk); #1;
            if (rstCyc > 0 && cyc == rstCyc + 1) begin
                checkResetState("midrst");
                rst       = 1'b0;
                req       = '0;
                rrPtr     = 0;
                expResult = 0;
                expOvf    = 1'b0;
                return;
            end
            if (dropCyc > 0 && cyc == dropCyc + 1) begin
                checkOutput("abort_pulse", 32'(abort), 1);
                checkOutput("abort_busy",  32'(busy), 0);
                checkOutput("abort_gnt",   32'(gnt), 0);
                checkOutput("abort_rstn",  32'(add_rst_n), 0);
                checkOutput("abort_en",    32'(add_en), 0);
                checkOutput("abort_done",  32'(done), 0);
                checkOutput("abort_res",   32'(result), 32'(expResult));
                checkOutput("abort_ovf",   32'(ovf), 32'(expOvf));
                garbage();
                @(posedge clk); #1;
                checkOutput("post_abort_pulse", 32'(abort), 0);
                checkOutput("post_abort_busy",  32'(busy), 0);
                checkOutput("post_abort_rstn",  32'(add_rst_n), 1);
                checkOutput("post_abort_res",   32'(result), 32'(expResult));
                return;
            end
            if (cyc == 1) begin
                checkOutput("clr_busy", 32'(busy), 1);
                checkOutput("clr_gnt",  32'(gnt), 32'(expGnt));
                checkOutput("clr_rstn", 32'(add_rst_n), 0);
                checkOutput("clr_en",   32'(add_en), 0);
                checkOutput("clr_done", 32'(done), 0);
                checkOutput("clr_res",  32'(result), 32'(expResult));
                garbage();
            end else if (cyc <= LEN + 1) begin
                checkOutput("acc_en",   32'(add_en), 1);
                checkOutput("acc_rw",   32'(add_rw), 0);
                checkOutput("acc_rstn", 32'(add_rst_n), 1);
                checkOutput("acc_gnt",  32'(gnt), 32'(expGnt));
                if (doutMode == 2) begin
                    patBit = ((cyc - 2) % 2) == 0;
                    req_a  = {NREQ{patBit}};
                    req_b  = {NREQ{patBit}};
                end else begin
                    req_a = NREQ'($urandom);
                    req_b = NREQ'($urandom);
                end
                req      = expGnt | (other & NREQ'($urandom));
                add_dout = 1'($urandom_range(0, 1));
                add_c    = (cMode == 1) ? ($urandom_range(0, 39) == 0) : (cMode == 2 && cyc == 4);
                cSeen    = cSeen | add_c;
                #1;
                checkOutput("acc_a", 32'(add_a), 32'(req_a[win]));
                checkOutput("acc_b", 32'(add_b), 32'(req_b[win]));
            end else if (cyc <= 3 * LEN + 1) begin
                checkOutput("rd_en",  32'(add_en), 1);
                checkOutput("rd_rw",  32'(add_rw), 1);
                checkOutput("rd_gnt", 32'(gnt), 32'(expGnt));
                req_a = NREQ'($urandom);
                req_b = NREQ'($urandom);
                req   = expGnt | (other & NREQ'($urandom));
                case (doutMode)
                    1:       add_dout = 1'b1;
                    2:       add_dout = ((cyc - LEN - 2) % 2) == 0;
                    default: add_dout = 1'($urandom_range(0, 1));
                endcase
                onesCnt += int'(add_dout);
                add_c    = (cMode == 1) ? ($urandom_range(0, 39) == 0) : 1'b0;
                cSeen    = cSeen | add_c;
                #1;
                checkOutput("rd_a", 32'(add_a), 0);
                checkOutput("rd_b", 32'(add_b), 0);
            end else begin
                expResult = (onesCnt > RESMAX) ? RESMAX : onesCnt;
                expOvf    = cSeen || (onesCnt > RESMAX);
                checkOutput("done_pulse", 32'(done), 1);
                checkOutput("done_gnt",   32'(gnt), 32'(expGnt));
                checkOutput("done_busy",  32'(busy), 1);
                checkOutput("done_en",    32'(add_en), 0);
                checkOutput("done_res",   32'(result), 32'(expResult));
                checkOutput("done_ovf",   32'(ovf), 32'(expOvf));
                req = reqMask;
                garbage();
            end
            if (cyc == dropCyc) req = '0;
            if (cyc == rstCyc) rst = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_done", 32'(done), 0);
        checkOutput("end_gnt",  32'(gnt), 0);
        checkOutput("end_rw",   32'(add_rw), 0);
        checkOutput("end_rstn", 32'(add_rst_n), 1);
        checkOutput("end_res",  32'(result), 32'(expResult));
        checkOutput("end_ovf",  32'(ovf), 32'(expOvf));
    endtask

    // Directed scenarios followed by randomized jobs.
    initial begin
        logic [NREQ-1:0] mask;
        int              drop;
        rst      = 1'b1;
        req      = '0;
        req_a    = '0;
        req_b    = '0;
        add_dout = 1'b0;
        add_c    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checkResetState("reset");
        end
        rst = 1'b0;

        applyStimulus(2'b01, 0, 0, 2, 0);
        idleCycles(2);

        for (int k = 0; k < 4; k++) applyStimulus(2'b11, 0, 0, 0, 0);
        idleCycles(1);

        applyStimulus(2'b01, 0, 0, 1, 0);
        idleCycles(1);
        applyStimulus(2'b10, 0, 0, 0, 2);
        idleCycles(1);

        applyStimulus(2'b01, 6, 0, 0, 0);
        idleCycles(1);
        applyStimulus(2'b10, LEN + 5, 0, 0, 1);
        idleCycles(1);

        for (int k = 0; k < 10; k++) begin
            mask = NREQ'($urandom_range(1, 3));
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * LEN + 1) : 0;
            applyStimulus(mask, drop, 0, 0, 1);
            if (drop != 0 || $urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
        end
        idleCycles(1);

        applyStimulus(2'b01, 0, 0, 0, 0);
        applyStimulus(2'b10, 0, LEN + 11, 0, 0);
        applyStimulus(2'b11, 0, 0, 0, 0);
        idleCycles(1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
